// File: rtl/act_quant_lanes.sv
// Multi-lane post-accumulator pipeline: activation, affine requantisation, rounding and
// saturation to OUT_W-bit lanes, with per-frame configuration carried alongside each beat.
module act_quant_lanes #(
    parameter int LANES   = 4,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int SCALE_W = 16,
    parameter int FRAC    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*ACC_W-1:0] in_data,
    input  logic                   in_last,
    input  logic [1:0]             cfg_mode,
    input  logic [4:0]             cfg_leak_shift,
    input  logic [ACC_W-1:0]       cfg_clip_hi,
    input  logic [SCALE_W-1:0]     cfg_inv_scale,
    input  logic [OUT_W-1:0]       cfg_zero_point,
    input  logic                   clear_stats,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_last,
    output logic [15:0]            sat_count
);

    localparam int P_W = ACC_W + SCALE_W;
    localparam int R_W = P_W + 1;
    localparam logic signed [R_W-1:0] HALF  = R_W'(1 << (FRAC - 1));
    localparam logic signed [R_W-1:0] Q_MAX = R_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [R_W-1:0] Q_MIN = ~Q_MAX;

    typedef enum logic {ST_IDLE, ST_IN_FRAME} state_t;

    typedef struct packed {
        logic [1:0]         mode;
        logic [4:0]         leak_shift;
        logic [ACC_W-1:0]   clip_hi;
        logic [SCALE_W-1:0] inv_scale;
        logic [OUT_W-1:0]   zero_point;
    } cfg_t;

    state_t r_state, w_state_next;
    cfg_t   r_cfg, w_cfg_live, w_cfg_beat;
    logic   w_cfg_load, w_advance, w_accept;

    // Pipeline stage registers; scale and zero point ride along with their beat.
    logic                      r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid;
    logic                      r_s1_last, r_s2_last, r_s3_last, r_s4_last;
    logic signed [ACC_W-1:0]   r_s1_y [LANES];
    logic        [SCALE_W-1:0] r_s1_scale;
    logic        [OUT_W-1:0]   r_s1_zp, r_s2_zp;
    logic signed [P_W-1:0]     r_s2_p [LANES];
    logic signed [R_W-1:0]     r_s3_r [LANES];
    logic        [OUT_W-1:0]   r_s4_q [LANES];
    logic        [LANES-1:0]   r_s4_flag;
    logic        [15:0]        r_sat_count;

    logic signed [ACC_W-1:0]   w_x [LANES];
    logic signed [ACC_W-1:0]   w_y [LANES];
    logic signed [P_W-1:0]     w_p [LANES];
    logic signed [R_W-1:0]     w_pe [LANES];
    logic signed [R_W-1:0]     w_rs [LANES];
    logic signed [R_W-1:0]     w_r [LANES];
    logic signed [R_W-1:0]     w_zp_ext;
    logic        [OUT_W-1:0]   w_q [LANES];
    logic        [LANES-1:0]   w_flag;
    logic        [16:0]        w_pop, w_sat_sum;

    assign w_advance  = !r_s4_valid || out_ready;
    assign in_ready   = w_advance && !reset;
    assign w_accept   = in_valid && in_ready;
    assign w_cfg_live = '{mode: cfg_mode, leak_shift: cfg_leak_shift, clip_hi: cfg_clip_hi,
                          inv_scale: cfg_inv_scale, zero_point: cfg_zero_point};

    // Frame FSM: state register, next-state logic, output logic.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            case (r_state)
                ST_IDLE:     if (!in_last) w_state_next = ST_IN_FRAME;
                ST_IN_FRAME: if (in_last)  w_state_next = ST_IDLE;
                default:     w_state_next = ST_IDLE;
            endcase
        end
    end

    // The first beat of a frame uses the live settings it is latching.
    always_comb begin
        w_cfg_load = w_accept && (r_state == ST_IDLE);
        w_cfg_beat = (r_state == ST_IDLE) ? w_cfg_live : r_cfg;
    end

    always_ff @(posedge clk) begin
        if (reset)           r_cfg <= '0;
        else if (w_cfg_load) r_cfg <= w_cfg_live;
    end

    // S1 activation.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_x[i] = $signed(in_data[i*ACC_W +: ACC_W]);
            w_y[i] = w_x[i];
            case (w_cfg_beat.mode)
                2'd1: if (w_x[i][ACC_W-1]) w_y[i] = '0;
                2'd2: if (w_x[i][ACC_W-1]) w_y[i] = w_x[i] >>> w_cfg_beat.leak_shift;
                2'd3: begin
                    if (w_x[i][ACC_W-1])                        w_y[i] = '0;
                    else if (w_x[i] > $signed(w_cfg_beat.clip_hi)) w_y[i] = $signed(w_cfg_beat.clip_hi);
                end
                default: w_y[i] = w_x[i];
            endcase
        end
    end

    // S2 full-width product; operands are sign-extended to the product width first.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_p[i] = {{SCALE_W{r_s1_y[i][ACC_W-1]}}, r_s1_y[i]}
                   * {{ACC_W{r_s1_scale[SCALE_W-1]}}, r_s1_scale};
        end
    end

    // S3 round half up, then offset. The shift stays in its own signed expression so it is arithmetic.
    always_comb begin
        w_zp_ext = {{(R_W-OUT_W){r_s2_zp[OUT_W-1]}}, r_s2_zp};
        for (int i = 0; i < LANES; i++) begin
            w_pe[i] = {r_s2_p[i][P_W-1], r_s2_p[i]};
            w_rs[i] = (w_pe[i] + HALF) >>> FRAC;
            w_r[i]  = w_rs[i] + w_zp_ext;
        end
    end

    // S4 saturation.
    always_comb begin
        w_flag = '0;
        for (int i = 0; i < LANES; i++) begin
            w_q[i] = r_s3_r[i][OUT_W-1:0];
            if (r_s3_r[i] > Q_MAX) begin
                w_q[i]    = Q_MAX[OUT_W-1:0];
                w_flag[i] = 1'b1;
            end else if (r_s3_r[i] < Q_MIN) begin
                w_q[i]    = Q_MIN[OUT_W-1:0];
                w_flag[i] = 1'b1;
            end
        end
    end

    // NOTE: every stage register is reset, because out_data must read zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            {r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid} <= '0;
            {r_s1_last, r_s2_last, r_s3_last, r_s4_last}     <= '0;
            r_s1_scale <= '0;
            r_s1_zp    <= '0;
            r_s2_zp    <= '0;
            r_s4_flag  <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_s1_y[i] <= '0;
                r_s2_p[i] <= '0;
                r_s3_r[i] <= '0;
                r_s4_q[i] <= '0;
            end
        end else if (w_advance) begin
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            r_s4_valid <= r_s3_valid;
            r_s1_last  <= in_last;
            r_s2_last  <= r_s1_last;
            r_s3_last  <= r_s2_last;
            r_s4_last  <= r_s3_last;
            r_s1_scale <= w_cfg_beat.inv_scale;
            r_s1_zp    <= w_cfg_beat.zero_point;
            r_s2_zp    <= r_s1_zp;
            r_s4_flag  <= w_flag;
            for (int i = 0; i < LANES; i++) begin
                r_s1_y[i] <= w_y[i];
                r_s2_p[i] <= w_p[i];
                r_s3_r[i] <= w_r[i];
                r_s4_q[i] <= w_q[i];
            end
        end
    end

    // Saturation statistics, sticky at all-ones.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LANES; i++) w_pop = w_pop + 17'(r_s4_flag[i]);
        w_sat_sum = {1'b0, r_sat_count} + w_pop;
    end

    always_ff @(posedge clk) begin
        if (reset || clear_stats)          r_sat_count <= '0;
        else if (r_s4_valid && out_ready) r_sat_count <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++) out_data[i*OUT_W +: OUT_W] = r_s4_q[i];
    end

    assign out_valid = r_s4_valid;
    assign out_last  = r_s4_last;
    assign sat_count = r_sat_count;

endmodule

// File: tb/tb_act_quant_lanes.sv
// Directed bench for act_quant_lanes: hand-computed vectors covering activation modes,
// requantisation, frame config latching, backpressure, reset and saturation statistics.
`timescale 1ns/1ps
module tb_act_quant_lanes;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_last;
    logic [127:0] in_data;
    logic [1:0]   cfg_mode;
    logic [4:0]   cfg_leak_shift;
    logic [31:0]  cfg_clip_hi;
    logic [15:0]  cfg_inv_scale;
    logic [7:0]   cfg_zero_point;
    logic         clear_stats;
    logic         out_valid, out_ready, out_last;
    logic [31:0]  out_data;
    logic [15:0]  sat_count;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] b_data [8];
    logic         b_last [8];
    logic [1:0]   b_mode [8];
    logic [31:0]  e_data [8];
    logic         e_last [8];

    act_quant_lanes dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .cfg_mode(cfg_mode), .cfg_leak_shift(cfg_leak_shift), .cfg_clip_hi(cfg_clip_hi),
        .cfg_inv_scale(cfg_inv_scale), .cfg_zero_point(cfg_zero_point),
        .clear_stats(clear_stats),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pk_in(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    function automatic logic [31:0] pk_out(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    task automatic set_cfg(input int mode, input int shift, input int clip, input int scale, input int zp);
        cfg_mode       = mode[1:0];
        cfg_leak_shift = shift[4:0];
        cfg_clip_hi    = clip;
        cfg_inv_scale  = scale[15:0];
        cfg_zero_point = zp[7:0];
    endtask

    // One beat, checked for exact latency; ends on the negedge where the result is valid.
    task automatic run1(input string tag, input logic [127:0] din, input logic dlast,
                        input logic [31:0] exp_out, input logic exp_last);
        @(negedge clk);
        in_valid = 1'b1; in_data = din; in_last = dlast;
        #1 check({tag, " in_ready"}, 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, " early"}, 128'(out_valid), 128'(0));
        @(negedge clk);
        check({tag, " valid"}, 128'(out_valid), 128'(1));
        check({tag, " data"},  128'(out_data),  128'(exp_out));
        check({tag, " last"},  128'(out_last),  128'(exp_last));
    endtask

    // Streams n beats from the b_* tables, dropping out_ready over cycles st_lo..st_hi.
    task automatic stream(input string tag, input int n, input int st_lo, input int st_hi);
        int in_idx = 0;
        int out_idx = 0;
        int c = 0;
        logic stalled = 1'b0;
        logic [32:0] held = '0;
        while (out_idx < n && c < 60) begin
            @(negedge clk);
            c++;
            if (stalled) check({tag, " hold"}, 128'({out_last, out_data}), 128'(held));
            out_ready = !(c >= st_lo && c <= st_hi);
            if (in_idx < n) begin
                in_valid = 1'b1; in_data = b_data[in_idx];
                in_last = b_last[in_idx]; cfg_mode = b_mode[in_idx];
            end else begin
                in_valid = 1'b0; in_last = 1'b0;
            end
            #1 check({tag, " in_ready"}, 128'(in_ready), 128'(!out_valid || out_ready));
            if (out_valid && out_ready) begin
                check({tag, " data"}, 128'(out_data), 128'(e_data[out_idx]));
                check({tag, " last"}, 128'(out_last), 128'(e_last[out_idx]));
                out_idx++;
            end
            stalled = out_valid && !out_ready;
            held = {out_last, out_data};
            if (in_valid && in_ready) in_idx++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        check({tag, " count"}, 128'(out_idx), 128'(n));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        clear_stats = 1'b0; out_ready = 1'b1;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst out_valid", 128'(out_valid), 128'(0));
        check("rst out_data",  128'(out_data),  128'(0));
        check("rst sat",       128'(sat_count), 128'(0));
        check("rst in_ready",  128'(in_ready),  128'(0));
        reset = 1'b0;
        #1 check("in_ready after rst", 128'(in_ready), 128'(1));

        // ReLU, unit scale.
        set_cfg(1, 0, 0, 16'h0100, 0);
        run1("relu", pk_in(-5, 3, 200, 127), 1'b1, pk_out(0, 3, 127, 127), 1'b1);
        @(negedge clk);
        check("relu sat", 128'(sat_count), 128'(1));

        // Leaky ReLU and clamped ReLU.
        set_cfg(2, 2, 0, 16'h0100, 0);
        run1("leaky", pk_in(-8, -7, -1, 4), 1'b1, pk_out(-2, -2, -1, 4), 1'b1);
        set_cfg(3, 0, 6, 16'h0100, 0);
        run1("clamp", pk_in(10, -3, 6, 5), 1'b1, pk_out(6, 0, 6, 5), 1'b1);
        @(negedge clk);
        check("clamp sat", 128'(sat_count), 128'(1));

        // Half scale with negative zero point; both ends of the output range.
        set_cfg(0, 0, 0, 16'h0080, -3);
        run1("scale", pk_in(3, 1, -1, 300), 1'b1, pk_out(-1, -2, -3, 127), 1'b1);
        run1("neg sat", pk_in(-1000, 0, 0, 0), 1'b1, pk_out(-128, -3, -3, -3), 1'b1);
        @(negedge clk);
        check("scale sat", 128'(sat_count), 128'(3));

        // 3-beat ReLU frame with mode changed mid-frame, then a mode-0 frame behind it.
        set_cfg(1, 0, 0, 16'h0100, 0);
        b_data[0] = pk_in(-1, 2, -3, 4);      b_mode[0] = 2'd1; b_last[0] = 1'b0; e_data[0] = pk_out(0, 2, 0, 4);
        b_data[1] = pk_in(-10, 10, -20, 20);  b_mode[1] = 2'd0; b_last[1] = 1'b0; e_data[1] = pk_out(0, 10, 0, 20);
        b_data[2] = pk_in(-100, 100, -5, 5);  b_mode[2] = 2'd0; b_last[2] = 1'b1; e_data[2] = pk_out(0, 100, 0, 5);
        b_data[3] = pk_in(-1, 2, -3, 4);      b_mode[3] = 2'd0; b_last[3] = 1'b1; e_data[3] = pk_out(-1, 2, -3, 4);
        e_last[0] = 1'b0; e_last[1] = 1'b0; e_last[2] = 1'b1; e_last[3] = 1'b1;
        stream("frame", 4, 0, -1);

        // 8-beat burst with output stalled over cycles 5..8.
        set_cfg(0, 0, 0, 16'h0100, 0);
        for (int k = 0; k < 8; k++) begin
            b_data[k] = pk_in(k + 1, -(k + 1), 10 * (k + 1), -10 * (k + 1));
            e_data[k] = pk_out(k + 1, -(k + 1), 10 * (k + 1), -10 * (k + 1));
            b_mode[k] = 2'd0;
            b_last[k] = (k == 7);
            e_last[k] = (k == 7);
        end
        stream("burst", 8, 5, 8);
        check("burst sat", 128'(sat_count), 128'(3));

        // Reset mid-frame with three beats in flight.
        set_cfg(1, 0, 0, 16'h0100, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_last = 1'b0; in_data = pk_in(5, 6, 7, 8);
        end
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        check("mid rst valid", 128'(out_valid), 128'(0));
        check("mid rst data",  128'(out_data),  128'(0));
        check("mid rst last",  128'(out_last),  128'(0));
        check("mid rst sat",   128'(sat_count), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post rst valid", 128'(out_valid), 128'(0));
        set_cfg(2, 1, 0, 16'h0100, 0);
        run1("fresh cfg", pk_in(-8, -3, 5, 0), 1'b1, pk_out(-4, -2, 5, 0), 1'b1);

        // Saturation counting and clear priority over a same-cycle increment.
        set_cfg(0, 0, 0, 16'h0100, 0);
        run1("sat2", pk_in(200, -200, 0, 0), 1'b1, pk_out(127, -128, 0, 0), 1'b1);
        @(negedge clk);
        check("sat2 count", 128'(sat_count), 128'(2));
        run1("sat clr", pk_in(200, -200, 0, 0), 1'b1, pk_out(127, -128, 0, 0), 1'b1);
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        check("clear priority", 128'(sat_count), 128'(0));

        // Counter sticks at all-ones: 16400 beats of four saturating lanes.
        set_cfg(0, 0, 0, 16'h7FFF, 0);
        @(negedge clk);
        in_valid = 1'b1; in_last = 1'b1; in_data = pk_in(1000, 1000, 1000, 1000);
        repeat (16400) @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("sticky", 128'(sat_count), 128'(16'hFFFF));
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        check("clear", 128'(sat_count), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
